// File: rtl/column_pkg.sv
// Shared constants and the packed column record for the column store.
// Optional height clamp is enabled by defining COLUMN_STORE_HEIGHT_CLAMP_EN.
package column_pkg;

    localparam int unsigned DEF_NUM_COLS   = 640;
    localparam int unsigned DEF_MAX_HEIGHT = 479;

    localparam int unsigned IDX_W = 10;
    localparam int unsigned HGT_W = 9;
    localparam int unsigned LIT_W = 2;
    localparam int unsigned TEX_W = 4;

    typedef struct packed {
        logic [HGT_W-1:0] height;
        logic [LIT_W-1:0] light;
        logic [TEX_W-1:0] tex;
    } column_rec_t;

endpackage

// File: rtl/column_store_if.sv
// Upstream column-record handshake between the height stage and the column store.
interface column_store_if;
    import column_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_index;
    logic [HGT_W-1:0] in_height;
    logic [LIT_W-1:0] in_light;
    logic [TEX_W-1:0] in_tex;

    modport master (
        output in_valid, in_index, in_height, in_light, in_tex,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_index, in_height, in_light, in_tex,
        output in_ready
    );

endinterface

// File: rtl/column_bank.sv
// One bank of column records: synchronous write, registered read.
module column_bank
    import column_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_NUM_COLS
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  column_rec_t      wdata,
    input  logic [IDX_W-1:0] raddr,
    output column_rec_t      rdata
);

    column_rec_t mem [DEPTH];

    // Out-of-range reads hold the last value; the top masks them to zero.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (32'(raddr) < DEPTH) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/column_store.sv
// Double-buffered per-column record store between the height and pixel stages.
// Define COLUMN_STORE_HEIGHT_CLAMP_EN to clamp stored heights to MAX_HEIGHT.
module column_store
    import column_pkg::*;
#(
    parameter int unsigned NUM_COLS   = DEF_NUM_COLS,
    parameter int unsigned MAX_HEIGHT = DEF_MAX_HEIGHT
) (
    input  logic             clk,
    input  logic             reset,
    column_store_if.slave    in_if,
    input  logic             frame_start,
    input  logic [IDX_W-1:0] rd_index,
    output logic [HGT_W-1:0] rd_height,
    output logic [LIT_W-1:0] rd_light,
    output logic [TEX_W-1:0] rd_tex,
    output logic             front_valid,
    output logic             compute_go,
    output logic [7:0]       dropped_frames
);

    localparam logic [0:0] FILL      = 1'b0;
    localparam logic [0:0] WAIT_SWAP = 1'b1;

`ifdef COLUMN_STORE_HEIGHT_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    logic [0:0]       state;
    logic             bank_sel;
    logic             filling;
    logic             wr_en;
    logic             wr_last;
    logic             we0;
    logic             we1;
    logic [HGT_W-1:0] wr_height;
    column_rec_t      wr_rec;
    column_rec_t      rd_rec0;
    column_rec_t      rd_rec1;
    column_rec_t      rd_rec;
    logic             rd_ok_q;
    logic             rd_bank_q;

    assign filling        = (state == FILL);
    assign in_if.in_ready = filling;
    assign compute_go     = filling;

    assign wr_en   = in_if.in_valid && filling && (32'(in_if.in_index) < NUM_COLS);
    assign wr_last = wr_en && (in_if.in_index == IDX_W'(NUM_COLS - 1));

    assign wr_height = (CLAMP_EN && (32'(in_if.in_height) > MAX_HEIGHT))
                       ? HGT_W'(MAX_HEIGHT) : in_if.in_height;
    assign wr_rec    = '{height: wr_height, light: in_if.in_light, tex: in_if.in_tex};

    // Writes always target the back bank, i.e. the one not selected by bank_sel.
    assign we0 = wr_en && bank_sel;
    assign we1 = wr_en && !bank_sel;

    column_bank #(.DEPTH(NUM_COLS)) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .waddr (in_if.in_index),
        .wdata (wr_rec),
        .raddr (rd_index),
        .rdata (rd_rec0)
    );

    column_bank #(.DEPTH(NUM_COLS)) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .waddr (in_if.in_index),
        .wdata (wr_rec),
        .raddr (rd_index),
        .rdata (rd_rec1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FILL;
            bank_sel       <= 1'b0;
            front_valid    <= 1'b0;
            dropped_frames <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (frame_start && wr_last) begin
                        bank_sel    <= !bank_sel;
                        front_valid <= 1'b1;
                    end else if (wr_last) begin
                        state <= WAIT_SWAP;
                    end else if (frame_start && (dropped_frames != '1)) begin
                        dropped_frames <= dropped_frames + 8'd1;
                    end
                end
                default: begin
                    if (frame_start) begin
                        bank_sel    <= !bank_sel;
                        front_valid <= 1'b1;
                        state       <= FILL;
                    end
                end
            endcase
        end
    end

    // Bank choice and validity are captured with the read address so a swap
    // edge still returns the pre-swap front bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ok_q   <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            rd_ok_q   <= front_valid && (32'(rd_index) < NUM_COLS);
            rd_bank_q <= bank_sel;
        end
    end

    assign rd_rec    = rd_ok_q ? (rd_bank_q ? rd_rec1 : rd_rec0) : '0;
    assign rd_height = rd_rec.height;
    assign rd_light  = rd_rec.light;
    assign rd_tex    = rd_rec.tex;

endmodule

// File: tb/tb_column_store.sv
// Randomized self-checking bench for column_store against a frame-level model.
module tb_column_store;
    import column_pkg::*;

    localparam int NC   = DEF_NUM_COLS;
    localparam int MAXH = DEF_MAX_HEIGHT;

    logic             clk = 1'b0;
    logic             reset;
    logic             frame_start;
    logic [IDX_W-1:0] rd_index;
    logic [HGT_W-1:0] rd_height;
    logic [LIT_W-1:0] rd_light;
    logic [TEX_W-1:0] rd_tex;
    logic             front_valid;
    logic             compute_go;
    logic [7:0]       dropped_frames;

    column_store_if bus ();

    column_store #(.NUM_COLS(NC), .MAX_HEIGHT(MAXH)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_if          (bus.slave),
        .frame_start    (frame_start),
        .rd_index       (rd_index),
        .rd_height      (rd_height),
        .rd_light       (rd_light),
        .rd_tex         (rd_tex),
        .front_valid    (front_valid),
        .compute_go     (compute_go),
        .dropped_frames (dropped_frames)
    );

    always #5 clk = ~clk;

    // Model: two record arrays, which one is displayed, and frame bookkeeping.
    int unsigned m_h [2][NC];
    int unsigned m_l [2][NC];
    int unsigned m_t [2][NC];
    int          m_front;
    bit          m_fv;
    bit          m_full;
    int unsigned m_drop;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_front = 0;
        m_fv    = 1'b0;
        m_full  = 1'b0;
        m_drop  = 0;
    endtask

    task automatic drive(input bit v, input int idx, input int h, input bit fs, input int rd);
        bus.in_valid  = v;
        bus.in_index  = IDX_W'(idx);
        bus.in_height = HGT_W'(h);
        bus.in_light  = LIT_W'($urandom);
        bus.in_tex    = TEX_W'($urandom);
        frame_start   = fs;
        rd_index      = IDX_W'(rd);
    endtask

    // One clock: predict from the current inputs, advance, then compare.
    task automatic cycle();
        int unsigned eh, el, et, hst, idx;
        int          back;
        bit          stored, completes;
        eh = 0; el = 0; et = 0;
        if (m_fv && (int'(rd_index) < NC)) begin
            eh = m_h[m_front][rd_index];
            el = m_l[m_front][rd_index];
            et = m_t[m_front][rd_index];
        end
        back      = 1 - m_front;
        stored    = bus.in_valid && !m_full && (int'(bus.in_index) < NC);
        completes = stored && (int'(bus.in_index) == NC - 1);
        if (stored) begin
            idx = bus.in_index;
            hst = bus.in_height;
`ifdef COLUMN_STORE_HEIGHT_CLAMP_EN
            if (hst > MAXH) hst = MAXH;
`endif
            m_h[back][idx] = hst;
            m_l[back][idx] = bus.in_light;
            m_t[back][idx] = bus.in_tex;
        end
        if (frame_start && (m_full || completes)) begin
            m_front = back;
            m_fv    = 1'b1;
            m_full  = 1'b0;
        end else if (completes) begin
            m_full = 1'b1;
        end else if (frame_start && m_drop < 255) begin
            m_drop++;
        end
        @(posedge clk);
        #1;
        check_eq("rd_height", 32'(rd_height), eh);
        check_eq("rd_light", 32'(rd_light), el);
        check_eq("rd_tex", 32'(rd_tex), et);
        check_eq("in_ready", 32'(bus.in_ready), 32'(!m_full));
        check_eq("compute_go", 32'(compute_go), 32'(!m_full));
        check_eq("front_valid", 32'(front_valid), 32'(m_fv));
        check_eq("dropped_frames", 32'(dropped_frames), m_drop);
    endtask

    // Sequential writes lo..hi with random bubbles; optional frame_start on the last one.
    task automatic write_range(input int lo, input int hi, input bit fs_on_last);
        int idx;
        bit v;
        idx = lo;
        while (idx <= hi) begin
            v = ($urandom_range(0, 3) != 0);
            drive(v, idx, idx % 512, fs_on_last && v && (idx == hi), $urandom_range(0, 1023));
            cycle();
            if (v) idx++;
        end
        drive(1'b0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        int ptr;
        bit v, oob, acc;
        model_reset();
        reset = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 0);
        #2 reset = 1'b1;
        #1;
        check_eq("reset_rd_height", 32'(rd_height), 0);
        check_eq("reset_front_valid", 32'(front_valid), 0);
        check_eq("reset_dropped", 32'(dropped_frames), 0);
        check_eq("reset_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Full frame with height = index, then swap.
        write_range(0, NC - 1, 1'b0);
        check_eq("wait_in_ready", 32'(bus.in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7, 9, 1'b0, $urandom_range(0, NC - 1));
            cycle();
        end
        drive(1'b0, 0, 0, 1'b1, 100);
        cycle();
        check_eq("swap_front_valid", 32'(front_valid), 1);
        drive(1'b0, 0, 0, 1'b0, 100);
        cycle();
        check_eq("rd100_height", 32'(rd_height), 100);
        drive(1'b0, 0, 0, 1'b0, 500);
        cycle();
`ifdef COLUMN_STORE_HEIGHT_CLAMP_EN
        check_eq("rd500_height", 32'(rd_height), 479);
`else
        check_eq("rd500_height", 32'(rd_height), 500);
`endif

        // Incomplete frame at frame_start counts a drop.
        write_range(0, 299, 1'b0);
        drive(1'b0, 0, 0, 1'b1, 100);
        cycle();
        check_eq("partial_dropped", 32'(dropped_frames), 1);
        check_eq("partial_in_ready", 32'(bus.in_ready), 1);
        drive(1'b0, 0, 0, 1'b0, 100);
        cycle();
        check_eq("partial_front_kept", 32'(rd_height), 100);

        // Out-of-range write is ignored; out-of-range read returns zeros.
        drive(1'b1, 700, 123, 1'b0, 700);
        cycle();
        drive(1'b0, 0, 0, 1'b0, 700);
        cycle();
        check_eq("rd700_height", 32'(rd_height), 0);
        check_eq("rd700_tex", 32'(rd_tex), 0);

        // Final write coincides with frame_start: swap without a drop.
        write_range(300, NC - 1, 1'b1);
        check_eq("coinc_dropped", 32'(dropped_frames), 1);
        check_eq("coinc_in_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 0, 0, 1'b0, $urandom_range(0, NC - 1));
            cycle();
        end

        // Asynchronous reset while waiting for the swap.
        write_range(0, NC - 1, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 100);
        cycle();
        check_eq("pre_reset_rd", 32'(rd_height), 100);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_eq("async_rd_height", 32'(rd_height), 0);
        check_eq("async_front_valid", 32'(front_valid), 0);
        check_eq("async_in_ready", 32'(bus.in_ready), 1);
        check_eq("async_dropped", 32'(dropped_frames), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b0, 0, 0, 1'b1, 100);
        cycle();
        check_eq("post_reset_drop", 32'(dropped_frames), 1);

        // Random traffic: sequential pointer with out-of-range injections.
        ptr = 0;
        for (int i = 0; i < 3000; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            oob = ($urandom_range(0, 15) == 0);
            acc = v && !m_full;
            drive(v, oob ? $urandom_range(NC, 1023) : ptr, $urandom_range(0, 511),
                  ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, NC - 1));
            cycle();
            if (acc && !oob) ptr = (ptr + 1) % NC;
        end

        // Drop counter saturation.
        if (!m_full) begin
            for (int i = 0; i < 270; i++) begin
                drive(1'b0, 0, 0, 1'b1, $urandom_range(0, NC - 1));
                cycle();
            end
            check_eq("drop_saturate", 32'(dropped_frames), 255);
        end else begin
            drive(1'b0, 0, 0, 1'b1, 0);
            cycle();
            for (int i = 0; i < 270; i++) begin
                drive(1'b0, 0, 0, 1'b1, $urandom_range(0, NC - 1));
                cycle();
            end
            check_eq("drop_saturate", 32'(dropped_frames), 255);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/column_store.md
COLUMN_STORE -- requirements
Module: column_store

Interface
REQ-001 SHALL have parameter NUM_COLS, default 640, meaning the number of screen columns per frame.
REQ-002 SHALL have parameter MAX_HEIGHT, default 479, meaning the largest legal stored wall height.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning the reset; it is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning the upstream height stage offers a column record.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the offered record this cycle.
REQ-007 SHALL have ports in_index (input, 10, column number), in_height (input, 9, wall height), in_light (input, 2, lighting shift) and in_tex (input, 4, texture column).
REQ-008 SHALL have port frame_start, input, 1, meaning a one-cycle pulse at the start of display vertical blanking.
REQ-009 SHALL have port rd_index, input, 10, meaning the column the pixel stage requests.
REQ-010 SHALL have ports rd_height (output, 9), rd_light (output, 2) and rd_tex (output, 4), meaning the front-bank record for rd_index.
REQ-011 SHALL have port front_valid, output, 1, meaning at least one complete frame has been swapped to the front.
REQ-012 SHALL have port compute_go, output, 1, meaning upstream may compute a new frame; it equals in_ready.
REQ-013 SHALL have port dropped_frames, output, 8, meaning a saturating count of frame_start pulses that arrived with an incomplete back bank.

Function
REQ-014 SHALL hold two banks of NUM_COLS records each; bank_sel selects the front bank, and the other bank is the back bank.
REQ-015 SHALL implement FSM states FILL and WAIT_SWAP; in_ready SHALL be 1 only in FILL.
REQ-016 SHALL accept a record when in_valid and in_ready are both high, writing {height, light, tex} to back[in_index] at that edge.
REQ-017 SHALL discard an accepted record with in_index >= NUM_COLS and leave the FSM unchanged.
REQ-018 SHALL move FILL->WAIT_SWAP when the record with in_index == NUM_COLS-1 is accepted.
REQ-019 SHALL, in WAIT_SWAP on frame_start, toggle bank_sel, set front_valid to 1 and move to FILL.
REQ-020 SHALL, on frame_start in FILL without a final-index write, keep bank_sel, increment dropped_frames (saturating at 255) and stay in FILL.
REQ-021 SHALL, when frame_start coincides with acceptance of index NUM_COLS-1, commit the write to the back bank, swap at the same edge, remain in FILL, and not count a drop.
REQ-022 SHALL return the front-bank record for rd_index registered, with 1-cycle latency.
REQ-023 SHALL return all-zero read data when rd_index >= NUM_COLS or front_valid is 0.
REQ-024 SHALL serve reads from the pre-swap front bank in the swap cycle and from the new front bank from the following cycle.

Reset
REQ-025 SHALL, on reset, force state FILL, bank_sel=0, front_valid=0, dropped_frames=0 and all rd_* outputs to 0 immediately; bank contents are undefined.
REQ-026 SHALL, on reset asserted mid-fill, discard any partial frame; the first frame_start after reset increments dropped_frames.

Configuration
REQ-027 SHALL, with COLUMN_STORE_HEIGHT_CLAMP_EN defined, store min(in_height, MAX_HEIGHT); without the macro, SHALL store in_height unmodified.

Structure
REQ-028 SHALL take NUM_COLS, MAX_HEIGHT, the field widths and a packed column-record typedef from the shared package column_pkg.
REQ-029 SHALL instantiate sub-module column_bank (synchronous write, registered read, one record per column) twice.

Verification
REQ-030 SHALL cover: reset, write indices 0..639 with height=index[8:0], pulse frame_start -> front_valid=1, and rd_index=100 gives rd_height=100 one cycle later.
REQ-031 SHALL cover: frame_start after only 300 writes -> dropped_frames=1, bank_sel unchanged, in_ready stays 1.
REQ-032 SHALL cover: final write of index 639 in the same cycle as frame_start -> swap occurs, dropped_frames=0, in_ready=1 next cycle.
REQ-033 SHALL cover: in_index=700 accepted -> no bank change; rd_index=700 returns zeros.
REQ-034 SHALL cover: in_height=500 -> reads 479 with COLUMN_STORE_HEIGHT_CLAMP_EN defined and 500 without it.
REQ-035 SHALL cover: reset asserted in WAIT_SWAP -> outputs zero asynchronously; state returns to FILL with front_valid=0.
